// File: rtl/rr_packet_arbiter_if.sv
// Handshake bundle between the flit sources, the packet arbiter and the output crossbar.
// The arbiter connects through the slave modport; the source/sink side uses master.
interface rr_packet_arbiter_if #(
  parameter int PORT_N = 5,
  parameter int SEL_W  = $clog2(PORT_N)
);
  logic [PORT_N-1:0] vld_input_i;
  logic [PORT_N-1:0] last_input_i;
  logic              out_rdy_i;
  logic [PORT_N-1:0] grant_o;
  logic [SEL_W-1:0]  mux_in_sel_o;
  logic              grant_vld_o;
  logic              xfer_o;

  modport master (
    output vld_input_i, last_input_i, out_rdy_i,
    input  grant_o, mux_in_sel_o, grant_vld_o, xfer_o
  );

  modport slave (
    input  vld_input_i, last_input_i, out_rdy_i,
    output grant_o, mux_in_sel_o, grant_vld_o, xfer_o
  );
endinterface

// File: rtl/rr_packet_arbiter.sv
// Wormhole packet arbiter: locks one input from head flit to tail flit, then
// re-arbitrates (round-robin or fixed highest-index priority) after one idle cycle.
module rr_packet_arbiter #(
  parameter int PORT_N  = 5,
  parameter int RR_MODE = 1,
  parameter int SEL_W   = $clog2(PORT_N)
) (
  input logic           clk_i,
  input logic           rst_i,
  rr_packet_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [PORT_N-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]  win;
  logic              any_req;
  logic              xfer;
  logic              tail;

  // First requester at or after ptr+1, wrapping at PORT_N.
  function automatic logic [SEL_W-1:0] pick_rr(input logic [PORT_N-1:0] req,
                                               input logic [SEL_W-1:0]  ptr);
    logic [SEL_W-1:0] res;
    logic             found;
    int               idx;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= PORT_N; k++) begin
      idx = (int'(ptr) + k) % PORT_N;
      if (!found && req[idx]) begin
        res   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [SEL_W-1:0] pick_hi(input logic [PORT_N-1:0] req);
    logic [SEL_W-1:0] res;
    res = '0;
    for (int k = 0; k < PORT_N; k++) begin
      if (req[k]) res = SEL_W'(k);
    end
    return res;
  endfunction

  assign any_req = |bus.vld_input_i;
  assign tail    = bus.last_input_i[sel_q];
  assign xfer    = (state_q == BUSY) && bus.vld_input_i[sel_q] && bus.out_rdy_i;

  always_comb begin
    win = (RR_MODE != 0) ? pick_rr(bus.vld_input_i, ptr_q) : pick_hi(bus.vld_input_i);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = BUSY;
          sel_d        = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
        end
      end
      BUSY: begin
        // Only the tail flit actually leaving releases the lock.
        if (xfer && tail) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(PORT_N - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign bus.grant_o      = grant_q;
  assign bus.mux_in_sel_o = sel_q;
  assign bus.grant_vld_o  = (state_q == BUSY);
  assign bus.xfer_o       = xfer;

  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(grant_q));
  a_grant_matches : assert property (@(posedge clk_i) disable iff (rst_i)
                                     (state_q == BUSY) == (grant_q != '0));

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed vector table plus hand sequences on 5-port builds, random fairness runs on 3/16 ports.
module tb_rr_packet_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic rand_go;
  int   rand_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  rr_packet_arbiter_if #(.PORT_N(5)) if0 ();
  rr_packet_arbiter #(.PORT_N(5), .RR_MODE(1)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));

  rr_packet_arbiter_if #(.PORT_N(5)) if1 ();
  rr_packet_arbiter #(.PORT_N(5), .RR_MODE(0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

  typedef struct {
    logic [4:0] vld;
    logic [4:0] last;
    logic       rdy;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       gvld;
    logic       xfer;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic [4:0] vld, logic [4:0] last, logic rdy,
                              logic [4:0] grant, logic [2:0] sel, logic gvld, logic xfer);
    vec_t v;
    v.vld = vld; v.last = last; v.rdy = rdy;
    v.grant = grant; v.sel = sel; v.gvld = gvld; v.xfer = xfer;
    return v;
  endfunction

  // Random-stimulus builds: one-hot grant, consistency and bounded waiting.
  for (genvar g = 0; g < 2; g++) begin : g_rand
    localparam int N = (g == 0) ? 3 : 16;
    rr_packet_arbiter_if #(.PORT_N(N)) rif ();
    rr_packet_arbiter #(.PORT_N(N), .RR_MODE(1)) rdut (.clk_i(clk), .rst_i(rst), .bus(rif));

    logic [N-1:0] active;
    logic [N-1:0] vld_n;
    logic [N-1:0] last_n;
    logic [N-1:0] prev_vld;
    logic [N-1:0] exp_g;
    logic         prev_gvld;
    logic         exp_x;
    int           wait_cnt [N];
    int           sel;

    initial begin
      rif.vld_input_i  = '0;
      rif.last_input_i = '0;
      rif.out_rdy_i    = 1'b0;
      active    = '0;
      prev_vld  = '0;
      prev_gvld = 1'b0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      wait (rand_go === 1'b1);
      for (int c = 0; c < 1500; c++) begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
          if (!active[i] && ($urandom_range(9, 0) < 4)) begin
            active[i]   = 1'b1;
            wait_cnt[i] = 0;
          end
          if (rif.grant_vld_o && (int'(rif.mux_in_sel_o) == i))
            vld_n[i] = active[i] && ($urandom_range(3, 0) != 0);
          else
            vld_n[i] = active[i];
          last_n[i] = vld_n[i] && ($urandom_range(9, 0) < 3);
        end
        rif.vld_input_i  = vld_n;
        rif.last_input_i = last_n;
        rif.out_rdy_i    = ($urandom_range(9, 0) < 7);
        @(negedge clk);
        sel   = int'(rif.mux_in_sel_o);
        exp_g = '0;
        if (rif.grant_vld_o) exp_g[sel] = 1'b1;
        exp_x = rif.grant_vld_o && vld_n[sel] && rif.out_rdy_i;
        chk("rnd_onehot", 32'($onehot0(rif.grant_o)), 32'd1);
        chk("rnd_grant", 32'(rif.grant_o), 32'(exp_g));
        chk("rnd_xfer", 32'(rif.xfer_o), 32'(exp_x));
        if (rif.grant_vld_o && !prev_gvld) begin
          chk("rnd_grant_to_requester", 32'(prev_vld[sel]), 32'd1);
          for (int i = 0; i < N; i++) begin
            if (i != sel && prev_vld[i]) begin
              wait_cnt[i]++;
              chk("rnd_starvation", 32'(wait_cnt[i] <= N - 1), 32'd1);
            end
          end
          wait_cnt[sel] = 0;
        end
        if (exp_x && last_n[sel]) active[sel] = 1'b0;
        prev_gvld = rif.grant_vld_o;
        prev_vld  = vld_n;
      end
      rif.vld_input_i = '0;
      rand_done++;
    end
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rand_go   = 1'b0;
    rand_done = 0;
    rst = 1'b1;
    if0.vld_input_i = '0; if0.last_input_i = '0; if0.out_rdy_i = 1'b0;
    if1.vld_input_i = '0; if1.last_input_i = '0; if1.out_rdy_i = 1'b0;

    //       vld       last      rdy   grant     sel gvld xfer
    vecs[0]  = mk(5'b10101, 5'b10101, 1, 5'b00000, 0, 0, 0);
    vecs[1]  = mk(5'b10101, 5'b10101, 1, 5'b00001, 0, 1, 1);
    vecs[2]  = mk(5'b10101, 5'b10101, 1, 5'b00000, 0, 0, 0);
    vecs[3]  = mk(5'b10101, 5'b10101, 1, 5'b00100, 2, 1, 1);
    vecs[4]  = mk(5'b10101, 5'b10101, 1, 5'b00000, 2, 0, 0);
    vecs[5]  = mk(5'b10101, 5'b10101, 1, 5'b10000, 4, 1, 1);
    vecs[6]  = mk(5'b10101, 5'b10101, 1, 5'b00000, 4, 0, 0);
    vecs[7]  = mk(5'b10101, 5'b10101, 1, 5'b00001, 0, 1, 1);
    vecs[8]  = mk(5'b10010, 5'b00000, 1, 5'b00000, 0, 0, 0);
    vecs[9]  = mk(5'b10010, 5'b00000, 1, 5'b00010, 1, 1, 1);
    vecs[10] = mk(5'b10010, 5'b00000, 1, 5'b00010, 1, 1, 1);
    vecs[11] = mk(5'b10010, 5'b00000, 1, 5'b00010, 1, 1, 1);
    vecs[12] = mk(5'b10010, 5'b00010, 1, 5'b00010, 1, 1, 1);
    vecs[13] = mk(5'b10000, 5'b10000, 1, 5'b00000, 1, 0, 0);
    vecs[14] = mk(5'b10000, 5'b10000, 0, 5'b10000, 4, 1, 0);
    vecs[15] = mk(5'b10000, 5'b10000, 1, 5'b10000, 4, 1, 1);
    vecs[16] = mk(5'b00100, 5'b00000, 1, 5'b00000, 4, 0, 0);
    vecs[17] = mk(5'b00100, 5'b00000, 1, 5'b00100, 2, 1, 1);
    vecs[18] = mk(5'b00000, 5'b00000, 1, 5'b00100, 2, 1, 0);
    vecs[19] = mk(5'b00000, 5'b00000, 0, 5'b00100, 2, 1, 0);
    vecs[20] = mk(5'b11011, 5'b11011, 1, 5'b00100, 2, 1, 0);
    vecs[21] = mk(5'b00100, 5'b00000, 0, 5'b00100, 2, 1, 0);
    vecs[22] = mk(5'b00100, 5'b00100, 1, 5'b00100, 2, 1, 1);
    vecs[23] = mk(5'b00000, 5'b00000, 1, 5'b00000, 2, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", 32'(if0.grant_o), 32'd0);
    chk("reset_sel", 32'(if0.mux_in_sel_o), 32'd0);
    chk("reset_gvld", 32'(if0.grant_vld_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if0.vld_input_i  = vecs[i].vld;
      if0.last_input_i = vecs[i].last;
      if0.out_rdy_i    = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), 32'(if0.grant_o), 32'(vecs[i].grant));
      chk($sformatf("vec%0d_sel", i), 32'(if0.mux_in_sel_o), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_gvld", i), 32'(if0.grant_vld_o), 32'(vecs[i].gvld));
      chk($sformatf("vec%0d_xfer", i), 32'(if0.xfer_o), 32'(vecs[i].xfer));
    end

    // Reset while locked on input 3, then re-grant right after release.
    @(posedge clk);
    #1;
    if0.vld_input_i = 5'b01000; if0.last_input_i = 5'b00000; if0.out_rdy_i = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_grant", 32'(if0.grant_o), 32'(5'b01000));
    chk("pre_rst_sel", 32'(if0.mux_in_sel_o), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_grant", 32'(if0.grant_o), 32'd0);
    chk("rst_mid_gvld", 32'(if0.grant_vld_o), 32'd0);
    chk("rst_mid_sel", 32'(if0.mux_in_sel_o), 32'd0);
    chk("rst_mid_xfer", 32'(if0.xfer_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("regrant_grant", 32'(if0.grant_o), 32'(5'b01000));
    chk("regrant_sel", 32'(if0.mux_in_sel_o), 32'd3);
    chk("regrant_gvld", 32'(if0.grant_vld_o), 32'd1);
    if0.last_input_i = 5'b01000;
    @(negedge clk);
    chk("regrant_xfer", 32'(if0.xfer_o), 32'd1);
    @(posedge clk);
    #1;
    if0.vld_input_i = 5'b00000; if0.last_input_i = 5'b00000;
    chk("release_grant", 32'(if0.grant_o), 32'd0);
    chk("release_sel_kept", 32'(if0.mux_in_sel_o), 32'd3);

    // Fixed priority: highest index among 1..3 always wins.
    if1.vld_input_i = 5'b01110; if1.last_input_i = 5'b01110; if1.out_rdy_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin
        chk($sformatf("fixed%0d_grant", c), 32'(if1.grant_o), 32'(5'b01000));
        chk($sformatf("fixed%0d_sel", c), 32'(if1.mux_in_sel_o), 32'd3);
        chk($sformatf("fixed%0d_xfer", c), 32'(if1.xfer_o), 32'd1);
      end else begin
        chk($sformatf("fixed%0d_grant", c), 32'(if1.grant_o), 32'd0);
        chk($sformatf("fixed%0d_gvld", c), 32'(if1.grant_vld_o), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    if1.vld_input_i = '0; if1.last_input_i = '0;

    rand_go = 1'b1;
    for (int t = 0; t < 5000 && rand_done < 2; t++) @(posedge clk);
    chk("random_runs_completed", 32'(rand_done), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_packet_arbiter.md
RR_PACKET_ARBITER -- requirements
Module: rr_packet_arbiter

Interface
REQ-001 SHALL have parameter PORT_N, default 5, number of input ports; legal range 2..16.
REQ-002 SHALL have parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority with highest index winning.
REQ-003 SHALL have derived parameter SEL_W, default $clog2(PORT_N), select width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  clock; all state updates on the rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 vld_input_i  input  PORT_N  per-input flit valid; bit i is input i.
REQ-008 last_input_i  input  PORT_N  per-input tail-flit flag; qualified only by vld_input_i of the same bit.
REQ-009 out_rdy_i  input  1  downstream accepts a flit this cycle.
REQ-010 grant_o  output  PORT_N  registered one-hot grant; all zero when no packet is locked.
REQ-011 mux_in_sel_o  output  SEL_W  registered index of the granted input, driving the crossbar mux.
REQ-012 grant_vld_o  output  1  high while a packet is locked (state BUSY).
REQ-013 xfer_o  output  1  combinational; equals grant_vld_o AND vld_input_i[mux_in_sel_o] AND out_rdy_i.

Function
REQ-014 SHALL implement two states: IDLE (no lock) and BUSY (one input locked for a whole packet).
REQ-015 IDLE, no vld_input_i bit set: SHALL remain in IDLE.
REQ-016 IDLE, any vld_input_i bit set: on the next edge SHALL select a winner, load mux_in_sel_o, set grant_o to that one-hot bit, and enter BUSY.
REQ-017 Arbitration latency SHALL be one cycle: xfer_o can first assert in the cycle after the request is seen in IDLE.
REQ-018 RR_MODE=1: search SHALL start at (ptr+1) mod PORT_N and proceed upward with wrap-around; the first set bit wins.
REQ-019 RR_MODE=0: the highest-index set bit SHALL win; ptr is unused.
REQ-020 BUSY: grant_o and mux_in_sel_o SHALL hold regardless of other inputs' vld_input_i (wormhole lock).
REQ-021 BUSY: if the locked input deasserts vld_input_i, the lock SHALL hold, xfer_o SHALL be 0, and no state SHALL change.
REQ-022 BUSY: xfer_o=1 with last_input_i[sel]=0 SHALL keep BUSY.
REQ-023 BUSY: xfer_o=1 with last_input_i[sel]=1 SHALL, on that edge, set ptr to sel, clear grant_o, drop grant_vld_o, and return to IDLE.
REQ-024 mux_in_sel_o SHALL retain its last value in IDLE.
REQ-025 A single-flit packet (head flit with last set) SHALL lock for exactly the cycles until its one transfer, then release.
REQ-026 out_rdy_i=0 SHALL stall the transfer without releasing the lock.
REQ-027 After a release there SHALL always be one IDLE bubble cycle before the next grant.
REQ-028 No two grant_o bits SHALL ever be set simultaneously.

Reset
REQ-029 rst_i high SHALL immediately force IDLE, grant_o=0, grant_vld_o=0, and mux_in_sel_o=0.
REQ-030 rst_i high SHALL set ptr to PORT_N-1, so the first round-robin search starts at input 0.
REQ-031 Reset asserted mid-packet SHALL abandon the lock with no transfer in that cycle; after deassertion, arbitration restarts from IDLE.

Verification
REQ-032 PORT_N=5, RR_MODE=1, after reset vld_input_i=5'b10101 held, all flits last, out_rdy_i=1 -> grants in order 0,2,4,0, each lasting 1 cycle with 1 IDLE cycle between.
REQ-033 RR_MODE=0, vld_input_i=5'b01110 held, single-flit packets -> grant always input 3; mux_in_sel_o=3.
REQ-034 Input 1 sends a 4-flit packet while input 4 requests continuously -> grant_o=5'b00010 for all 4 transfers, then input 4 is granted after 1 IDLE cycle.
REQ-035 Locked input 2 drops vld for 3 cycles mid-packet, and out_rdy_i toggles -> xfer_o=0 during those cycles, grant_o=5'b00100 unchanged, exactly 1 transfer per vld&rdy cycle.
REQ-036 rst_i pulsed while BUSY on input 3 -> grant_o=0, grant_vld_o=0, and mux_in_sel_o=0 in the same cycle; with vld_input_i=5'b01000 afterwards, input 3 is re-granted 1 cycle after reset release.
REQ-037 PORT_N=3 and PORT_N=16 builds under random vld/last/rdy stimulus -> grant_o is one-hot or zero, no starvation, and every active requester is granted within PORT_N packets.
